lock_mode_ctrl: RTL and testbench
=================================

// Module: lock_mode_ctrl
// PURPOSE
//  Top-level mode sequencer for the 3-digit (3x2-bit) password lock.
//  - Turns debounced button pulses into the 5-bit mode bus.
//  - The per-digit sequence checker consumes the mode bus: 1=SET, 2=CONFIRM, 3=ENTER, 4=CHECK.
//  - Owns the check time-out, failure counting, door-open timing and alarm lockout.
// PARAMETERS
//  CHECK_CYCLES  12   cycles spent in CHECK before a non-pass is declared a fail (>= 11)
//  OPEN_CYCLES   100  cycles open_o stays high after a pass
//  MAX_FAILS     3    consecutive fails that enter ALARM (1..7)
// PORTS
//  clk        in   1  system clock, all state on posedge
//  rst        in   1  asynchronous, active-low reset (0 = reset)
//  btn_set    in   1  1-cycle pulse: start password setting
//  btn_conf   in   1  1-cycle pulse: confirm new password
//  btn_verify in   1  1-cycle pulse: start a verify attempt
//  btn_check  in   1  1-cycle pulse: submit attempt
//  admin_i    in   1  admin key switch; needed to leave ALARM
//  pass_i     in   1  checker's pass LED (level)
//  mode_o     out  5  mode bus to checker: 0 IDLE, 1 SET, 2 CONFIRM, 3 ENTER, 4 CHECK, 5 OPEN, 6 ALARM
//  test_o     out  1  checker latch-inhibit; 0 only in CONFIRM
//  pw_valid_o out  1  a password has been confirmed since reset
//  open_o     out  1  door-open strobe
//  alarm_o    out  1  lockout indicator
//  fails_o    out  3  consecutive-fail count
// BEHAVIOUR
//  Reset (rst=0, any state): IDLE, mode_o=0, test_o=1, pw_valid_o=0, open_o=0, alarm_o=0,
//   fails_o=0, timer=0. No output glitches; fully registered Moore outputs.
//  Button priority when pulses coincide: set > conf > verify > check; lower-priority pulses are dropped.
//  Buttons not listed for the current state are ignored.
//  IDLE:
//   btn_set -> SET.
//   btn_verify with pw_valid_o=1 -> ENTER; with pw_valid_o=0 the pulse is ignored.
//  SET: btn_conf -> CONFIRM. btn_set re-enters SET (no effect).
//  CONFIRM: exactly 1 cycle with test_o=0 so the checker latches the digits.
//   Then -> IDLE and pw_valid_o<=1.
//  ENTER: minimum 1 cycle (clears checker count/flag). btn_check -> CHECK with timer cleared.
//   btn_set -> SET.
//  CHECK: timer increments every cycle.
//   pass_i=1 on any CHECK cycle -> OPEN; fails_o<=0; timer cleared.
//   pass_i beats the time-out if both occur in the same cycle.
//   timer==CHECK_CYCLES-1 without pass -> fails_o+1.
//    If the new count equals MAX_FAILS -> ALARM; otherwise -> IDLE.
//   Buttons are ignored in CHECK.
//  OPEN: open_o=1 for exactly OPEN_CYCLES cycles, then IDLE. btn_set is ignored.
//  ALARM: alarm_o=1. Only btn_set with admin_i=1 exits, to SET.
//   On that exit: fails_o<=0 and pw_valid_o<=0.
//  fails_o saturates at MAX_FAILS and never wraps. The timer width is clog2(max(CHECK_CYCLES,OPEN_CYCLES)).
//  Undefined state encodings recover to IDLE on the next clock.
// STRUCTURE
//  Include file lock_defs.vh holds:
//   - the mode encodings (IDLE..ALARM, 5-bit);
//   - the shared checker constants (check count limit 10).
//  The checker uses the same file.
//  One sub-module, mode_timer: a clear/enable up-counter with a terminal-count compare.
//  The FSM, fail counter and output registers stay in lock_mode_ctrl.
// TESTING
//  1 Reset mid-CHECK: rst=0 -> next observation mode_o=0, fails_o=0, pw_valid_o=0, test_o=1.
//  2 Set flow: btn_set, then btn_conf.
//    -> mode 1, then 2 for exactly 1 cycle with test_o=0, then 0; pw_valid_o=1.
//  3 Pass: verify, then check; pass_i rises on CHECK cycle 5.
//    -> mode_o=5, open_o high 100 cycles, then mode 0; fails_o=0.
//  4 Three fails: 3 attempts with pass_i=0.
//    -> each CHECK lasts 12 cycles; fails_o=1, then 2; third -> mode_o=6, alarm_o=1.
//  5 ALARM exit: btn_set with admin_i=0 -> stays 6.
//    With admin_i=1 -> mode 1, fails_o=0, pw_valid_o=0.
//  6 Coincidence: btn_set and btn_verify in the same IDLE cycle -> SET.
//    btn_verify with pw_valid_o=0 -> stays IDLE.
//    pass_i on the time-out cycle -> OPEN.

Source files
------------

// File: rtl/lock_mode_ctrl_pkg.sv
// Shared definitions for the password-lock mode sequencer and the per-digit checker.
// The checker decodes these mode values from the mode bus, so both sides must use the same encodings.
package lock_mode_ctrl_pkg;

  typedef enum logic [4:0] {
    MODE_IDLE    = 5'd0,
    MODE_SET     = 5'd1,
    MODE_CONFIRM = 5'd2,
    MODE_ENTER   = 5'd3,
    MODE_CHECK   = 5'd4,
    MODE_OPEN    = 5'd5,
    MODE_ALARM   = 5'd6
  } mode_e;

  // The checker's digit-count limit; CHECK must outlast it by at least one cycle.
  localparam int CHK_COUNT_LIMIT = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_mode_ctrl_mode_timer.sv
// Clear/enable up-counter with a terminal-count compare.
// The counter is shared by the CHECK time-out and the OPEN hold time.
module mode_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_i);

endmodule

// File: rtl/lock_mode_ctrl.sv
// Mode sequencer for the 3-digit password lock: turns button pulses into the mode bus
// and owns the check time-out, consecutive-fail count, door-open timing and alarm lockout.
module lock_mode_ctrl
  import lock_mode_ctrl_pkg::*;
#(
  parameter int CHECK_CYCLES = 12,
  parameter int OPEN_CYCLES  = 100,
  parameter int MAX_FAILS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_set,
  input  logic       btn_conf,
  input  logic       btn_verify,
  input  logic       btn_check,
  input  logic       admin_i,
  input  logic       pass_i,
  output logic [4:0] mode_o,
  output logic       test_o,
  output logic       pw_valid_o,
  output logic       open_o,
  output logic       alarm_o,
  output logic [2:0] fails_o
);

  localparam int TW = $clog2(max_int(CHECK_CYCLES, OPEN_CYCLES));

  mode_e      state_q, state_d;
  logic [2:0] fails_q, fails_d, fails_inc;
  logic       pw_valid_q, pw_valid_d;
  logic       test_q, open_q, alarm_q;
  logic       timer_clr, timer_en, timer_tc;
  logic [TW-1:0] timer_tc_val;

  assign timer_tc_val = (state_q == MODE_CHECK) ? TW'(CHECK_CYCLES - 1) : TW'(OPEN_CYCLES - 1);
  // Every state change restarts the timer, so CHECK and OPEN always begin counting at zero.
  assign timer_clr    = (state_d != state_q);
  assign timer_en     = (state_q == MODE_CHECK) || (state_q == MODE_OPEN);

  mode_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_i  (timer_tc_val),
    .tc_o  (timer_tc)
  );

  always_comb begin
    state_d    = state_q;
    fails_d    = fails_q;
    pw_valid_d = pw_valid_q;
    fails_inc  = (fails_q < 3'(MAX_FAILS)) ? fails_q + 3'd1 : fails_q;
    case (state_q)
      MODE_IDLE: begin
        if (btn_set) begin
          state_d = MODE_SET;
        end else if (btn_verify && pw_valid_q) begin
          state_d = MODE_ENTER;
        end
      end
      MODE_SET: begin
        if (btn_set) begin
          state_d = MODE_SET;
        end else if (btn_conf) begin
          state_d = MODE_CONFIRM;
        end
      end
      MODE_CONFIRM: begin
        state_d    = MODE_IDLE;
        pw_valid_d = 1'b1;
      end
      MODE_ENTER: begin
        if (btn_set) begin
          state_d = MODE_SET;
        end else if (btn_check) begin
          state_d = MODE_CHECK;
        end
      end
      MODE_CHECK: begin
        // A pass on the time-out cycle still opens the door.
        if (pass_i) begin
          state_d = MODE_OPEN;
          fails_d = '0;
        end else if (timer_tc) begin
          fails_d = fails_inc;
          state_d = (fails_inc == 3'(MAX_FAILS)) ? MODE_ALARM : MODE_IDLE;
        end
      end
      MODE_OPEN: begin
        if (timer_tc) begin
          state_d = MODE_IDLE;
        end
      end
      MODE_ALARM: begin
        if (btn_set && admin_i) begin
          state_d    = MODE_SET;
          fails_d    = '0;
          pw_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = MODE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= MODE_IDLE;
      fails_q    <= '0;
      pw_valid_q <= 1'b0;
      test_q     <= 1'b1;
      open_q     <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fails_q    <= fails_d;
      pw_valid_q <= pw_valid_d;
      test_q     <= (state_d != MODE_CONFIRM);
      open_q     <= (state_d == MODE_OPEN);
      alarm_q    <= (state_d == MODE_ALARM);
    end
  end

  assign mode_o     = state_q;
  assign test_o     = test_q;
  assign pw_valid_o = pw_valid_q;
  assign open_o     = open_q;
  assign alarm_o    = alarm_q;
  assign fails_o    = fails_q;

endmodule

// File: tb/tb_lock_mode_ctrl.sv
// Self-checking bench for lock_mode_ctrl: table-driven set/confirm vectors plus
// hand-written pass, fail, alarm, time-out and reset sequences, checked through a scoreboard queue.
module tb_lock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_set = 1'b0, btn_conf = 1'b0, btn_verify = 1'b0, btn_check = 1'b0;
  logic       admin_i = 1'b0, pass_i = 1'b0;
  logic [4:0] mode_o;
  logic       test_o, pw_valid_o, open_o, alarm_o;
  logic [2:0] fails_o;

  lock_mode_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .btn_set    (btn_set),
    .btn_conf   (btn_conf),
    .btn_verify (btn_verify),
    .btn_check  (btn_check),
    .admin_i    (admin_i),
    .pass_i     (pass_i),
    .mode_o     (mode_o),
    .test_o     (test_o),
    .pw_valid_o (pw_valid_o),
    .open_o     (open_o),
    .alarm_o    (alarm_o),
    .fails_o    (fails_o)
  );

  always #5 clk = ~clk;

  // Input bit order: {set, conf, verify, check, admin, pass}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] SET  = 6'b100000;
  localparam logic [5:0] CONF = 6'b010000;
  localparam logic [5:0] VER  = 6'b001000;
  localparam logic [5:0] CHK  = 6'b000100;
  localparam logic [5:0] ADM  = 6'b000010;
  localparam logic [5:0] PAS  = 6'b000001;

  typedef struct {
    string      name;
    logic [5:0] in;
    logic [4:0] mode;
    logic       test;
    logic       pw;
    logic       open;
    logic       alarm;
    logic [2:0] fails;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string n, logic [5:0] in, logic [4:0] m, logic t, logic pw,
                              logic op, logic al, logic [2:0] f);
    vec_t v;
    v.name = n; v.in = in; v.mode = m; v.test = t; v.pw = pw;
    v.open = op; v.alarm = al; v.fails = f;
    return v;
  endfunction

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue, required one pending expectation");
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({mode_o, test_o, pw_valid_o, open_o, alarm_o, fails_o} !==
        {e.mode, e.test, e.pw, e.open, e.alarm, e.fails}) begin
      n_bad++;
      $display("FAIL %s: got mode=%0d test=%b pw=%b open=%b alarm=%b fails=%0d, required mode=%0d test=%b pw=%b open=%b alarm=%b fails=%0d",
               e.name, mode_o, test_o, pw_valid_o, open_o, alarm_o, fails_o,
               e.mode, e.test, e.pw, e.open, e.alarm, e.fails);
    end else begin
      $display("ok   %s: mode=%0d test=%b pw=%b open=%b alarm=%b fails=%0d",
               e.name, mode_o, test_o, pw_valid_o, open_o, alarm_o, fails_o);
    end
  endtask

  task automatic step(input vec_t v);
    {btn_set, btn_conf, btn_verify, btn_check, admin_i, pass_i} = v.in;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    {btn_set, btn_conf, btn_verify, btn_check, admin_i, pass_i} = NONE;
    check_out();
  endtask

  task automatic st(string n, logic [5:0] in, logic [4:0] m, logic t, logic pw,
                    logic op, logic al, logic [2:0] f);
    step(mk(n, in, m, t, pw, op, al, f));
  endtask

  initial begin
    tbl[0] = mk("verify_without_pw", VER,        5'd0, 1, 0, 0, 0, 3'd0);
    tbl[1] = mk("set",               SET,        5'd1, 1, 0, 0, 0, 3'd0);
    tbl[2] = mk("set_hold",          NONE,       5'd1, 1, 0, 0, 0, 3'd0);
    tbl[3] = mk("set_beats_conf",    SET | CONF, 5'd1, 1, 0, 0, 0, 3'd0);
    tbl[4] = mk("confirm",           CONF,       5'd2, 0, 0, 0, 0, 3'd0);
    tbl[5] = mk("confirm_done",      NONE,       5'd0, 1, 1, 0, 0, 3'd0);
    tbl[6] = mk("idle_hold",         NONE,       5'd0, 1, 1, 0, 0, 3'd0);
    tbl[7] = mk("set_beats_verify",  SET | VER,  5'd1, 1, 1, 0, 0, 3'd0);
    tbl[8] = mk("confirm2",          CONF,       5'd2, 0, 1, 0, 0, 3'd0);
    tbl[9] = mk("confirm2_done",     NONE,       5'd0, 1, 1, 0, 0, 3'd0);

    // Reset state
    @(posedge clk);
    #1;
    exp_q.push_back(mk("reset", NONE, 5'd0, 1, 0, 0, 0, 3'd0));
    check_out();
    rst = 1'b1;

    for (int i = 0; i < 10; i++) step(tbl[i]);

    // Pass on CHECK cycle 5, then 100 open cycles (btn_set ignored in CHECK and OPEN)
    st("verify", VER, 5'd3, 1, 1, 0, 0, 3'd0);
    st("check",  CHK, 5'd4, 1, 1, 0, 0, 3'd0);
    for (int c = 1; c <= 4; c++) st("check_wait", (c == 2) ? SET : NONE, 5'd4, 1, 1, 0, 0, 3'd0);
    st("pass_cycle5", PAS, 5'd5, 1, 1, 1, 0, 3'd0);
    for (int c = 2; c <= 100; c++) st("open_hold", (c == 50) ? SET : NONE, 5'd5, 1, 1, 1, 0, 3'd0);
    st("open_end", NONE, 5'd0, 1, 1, 0, 0, 3'd0);

    // Three consecutive time-outs
    for (int a = 1; a <= 3; a++) begin
      st("verify", VER, 5'd3, 1, 1, 0, 0, 3'(a - 1));
      st("check",  CHK, 5'd4, 1, 1, 0, 0, 3'(a - 1));
      for (int c = 1; c <= 11; c++) st("check_wait", NONE, 5'd4, 1, 1, 0, 0, 3'(a - 1));
      if (a < 3) st("timeout_fail", NONE, 5'd0, 1, 1, 0, 0, 3'(a));
      else       st("timeout_alarm", NONE, 5'd6, 1, 1, 0, 1, 3'd3);
    end

    // Alarm exit needs admin
    st("alarm_set_no_admin", SET,       5'd6, 1, 1, 0, 1, 3'd3);
    st("alarm_verify",       VER,       5'd6, 1, 1, 0, 1, 3'd3);
    st("alarm_admin_exit",   SET | ADM, 5'd1, 1, 0, 0, 0, 3'd0);
    st("confirm3",           CONF,      5'd2, 0, 0, 0, 0, 3'd0);
    st("confirm3_done",      NONE,      5'd0, 1, 1, 0, 0, 3'd0);

    // pass_i on the time-out cycle wins
    st("verify", VER, 5'd3, 1, 1, 0, 0, 3'd0);
    st("check",  CHK, 5'd4, 1, 1, 0, 0, 3'd0);
    for (int c = 1; c <= 11; c++) st("check_wait", NONE, 5'd4, 1, 1, 0, 0, 3'd0);
    st("pass_on_timeout", PAS, 5'd5, 1, 1, 1, 0, 3'd0);
    for (int c = 2; c <= 100; c++) st("open_hold", NONE, 5'd5, 1, 1, 1, 0, 3'd0);
    st("open_end", NONE, 5'd0, 1, 1, 0, 0, 3'd0);

    // One fail, then reset in the middle of the next CHECK
    st("verify", VER, 5'd3, 1, 1, 0, 0, 3'd0);
    st("check",  CHK, 5'd4, 1, 1, 0, 0, 3'd0);
    for (int c = 1; c <= 11; c++) st("check_wait", NONE, 5'd4, 1, 1, 0, 0, 3'd0);
    st("timeout_fail", NONE, 5'd0, 1, 1, 0, 0, 3'd1);
    st("enter_then_set", VER, 5'd3, 1, 1, 0, 0, 3'd1);
    st("enter_set_exit", SET, 5'd1, 1, 1, 0, 0, 3'd1);
    st("confirm4",       CONF, 5'd2, 0, 1, 0, 0, 3'd1);
    st("confirm4_done",  NONE, 5'd0, 1, 1, 0, 0, 3'd1);
    st("verify", VER, 5'd3, 1, 1, 0, 0, 3'd1);
    st("check",  CHK, 5'd4, 1, 1, 0, 0, 3'd1);
    for (int c = 1; c <= 3; c++) st("check_wait", NONE, 5'd4, 1, 1, 0, 0, 3'd1);
    rst = 1'b0;
    #2;
    exp_q.push_back(mk("reset_mid_check", NONE, 5'd0, 1, 0, 0, 0, 3'd0));
    check_out();
    @(posedge clk);
    #1;
    exp_q.push_back(mk("reset_held", NONE, 5'd0, 1, 0, 0, 0, 3'd0));
    check_out();
    rst = 1'b1;
    st("post_reset_idle",   NONE, 5'd0, 1, 0, 0, 0, 3'd0);
    st("post_reset_verify", VER,  5'd0, 1, 0, 0, 0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
